// File: rtl/mem_master_if.sv
// Bundles the command, V-register and byte-memory signals of the CHIP-8 memory master.
// The master modport is the engine; the slave modport is the CPU/register-file/memory side.
interface mem_master_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int IDX_WIDTH  = 4
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [1:0]            cmd_op;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [IDX_WIDTH-1:0]  cmd_count;
    logic                  done;
    logic [15:0]           opcode;

    logic [IDX_WIDTH-1:0]  reg_rd_idx;
    logic [7:0]            reg_rd_data;
    logic                  reg_wr;
    logic [IDX_WIDTH-1:0]  reg_wr_idx;
    logic [7:0]            reg_wr_data;

    logic                  mem_read;
    logic [ADDR_WIDTH-1:0] mem_read_addr;
    logic [7:0]            mem_read_data;
    logic                  mem_write;
    logic [ADDR_WIDTH-1:0] mem_write_addr;
    logic [7:0]            mem_write_data;

    modport master (
        input  cmd_valid, cmd_op, cmd_addr, cmd_count, reg_rd_data, mem_read_data,
        output cmd_ready, done, opcode, reg_rd_idx, reg_wr, reg_wr_idx, reg_wr_data,
               mem_read, mem_read_addr, mem_write, mem_write_addr, mem_write_data
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_addr, cmd_count, reg_rd_data, mem_read_data,
        input  cmd_ready, done, opcode, reg_rd_idx, reg_wr, reg_wr_idx, reg_wr_data,
               mem_read, mem_read_addr, mem_write, mem_write_addr, mem_write_data
    );
endinterface

// File: rtl/mem_master.sv
// CHIP-8 memory initiator: opcode fetch, FX55 register store and FX65 register load,
// one command at a time against a byte memory with one-cycle registered read data.
module mem_master #(
    parameter int ADDR_WIDTH = 12,
    parameter int IDX_WIDTH  = 4
) (
    input  logic         clk,
    input  logic         reset,
    mem_master_if.master bus
);
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_STORE, S_LOAD, S_DRAIN} state_t;

    localparam logic [1:0] OP_FETCH = 2'b00;
    localparam logic [1:0] OP_STORE = 2'b01;
    localparam logic [1:0] OP_LOAD  = 2'b10;

    state_t                state;
    state_t                state_nxt;
    logic                  accept;
    logic                  finish;
    logic [1:0]            op_q;
    logic                  done_q;
    logic                  rd_pend_q;
    logic [15:0]           opcode_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [IDX_WIDTH-1:0]  cnt_q;
    logic [IDX_WIDTH-1:0]  k_q;
    logic [IDX_WIDTH-1:0]  wr_idx_q;
    logic [7:0]            hi_q;

    assign accept   = bus.cmd_valid && (state == S_IDLE);
    assign cur_addr = addr_q + ADDR_WIDTH'(k_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // finish marks the last busy cycle; done follows it one cycle later
    always_comb begin
        state_nxt = state;
        finish    = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    case (bus.cmd_op)
                        OP_FETCH: state_nxt = S_FETCH;
                        OP_STORE: state_nxt = S_STORE;
                        OP_LOAD:  state_nxt = S_LOAD;
                        default:  finish    = 1'b1;
                    endcase
                end
            end
            S_FETCH: if (k_q == IDX_WIDTH'(1)) state_nxt = S_DRAIN;
            S_STORE: begin
                if (k_q == cnt_q) begin
                    state_nxt = S_IDLE;
                    finish    = 1'b1;
                end
            end
            S_LOAD:  if (k_q == cnt_q) state_nxt = S_DRAIN;
            S_DRAIN: begin
                state_nxt = S_IDLE;
                finish    = 1'b1;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q      <= '0;
            done_q    <= 1'b0;
            rd_pend_q <= 1'b0;
            opcode_q  <= '0;
        end else begin
            if (accept) op_q <= bus.cmd_op;
            done_q    <= finish;
            rd_pend_q <= (state == S_LOAD);
            if (state == S_DRAIN && op_q == OP_FETCH) opcode_q <= {hi_q, bus.mem_read_data};
        end
    end

    // Transfer bookkeeping; only meaningful while a command is active
    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q <= bus.cmd_addr;
            cnt_q  <= bus.cmd_count;
            k_q    <= '0;
        end else if (state == S_FETCH || state == S_STORE || state == S_LOAD) begin
            k_q <= k_q + IDX_WIDTH'(1);
        end
        wr_idx_q <= k_q;
        if (state == S_FETCH && k_q == IDX_WIDTH'(1)) hi_q <= bus.mem_read_data;
    end

    always_comb begin
        bus.cmd_ready      = (state == S_IDLE);
        bus.done           = done_q;
        bus.opcode         = opcode_q;
        bus.reg_rd_idx     = '0;
        bus.reg_wr         = 1'b0;
        bus.reg_wr_idx     = '0;
        bus.reg_wr_data    = '0;
        bus.mem_read       = 1'b0;
        bus.mem_read_addr  = '0;
        bus.mem_write      = 1'b0;
        bus.mem_write_addr = '0;
        bus.mem_write_data = '0;
        case (state)
            S_FETCH, S_LOAD: begin
                bus.mem_read      = 1'b1;
                bus.mem_read_addr = cur_addr;
            end
            S_STORE: begin
                bus.reg_rd_idx     = k_q;
                bus.mem_write      = 1'b1;
                bus.mem_write_addr = cur_addr;
                bus.mem_write_data = bus.reg_rd_data;
            end
            default: ;
        endcase
        // a load byte arrives one cycle after its read, including the drain cycle
        if (rd_pend_q) begin
            bus.reg_wr      = 1'b1;
            bus.reg_wr_idx  = wr_idx_q;
            bus.reg_wr_data = bus.mem_read_data;
        end
    end
endmodule
